// File: rtl/chess_board_store.sv
// chess_board_store
// Authoritative 8x8 chess board register file. Holds all 64 squares, comes out
// of reset in the opening position, applies single-square writes from game
// logic, and exposes the whole board as a packed vector. A registered read
// port serves the renderer. A 64-cycle sequencer reloads the opening layout
// on new_game. Move count, initial-position flag and last capture are kept
// here as well.
//
// Optional feature macro: BOARD_CAPTURE_LOG_EN
//   defined   -> white_lost / black_lost count captured pieces (saturate at 15)
//   undefined -> white_lost / black_lost tied to zero
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_piece single-square write (addr = {row, col})
//   new_game              pulse requesting a board reload
//   rd_addr / rd_piece    renderer read port, one-cycle latency, pre-write data
//   board                 packed board, square n at [4n+3:4n]
//   busy                  reload in progress; writes are dropped
//   is_in_initial_state   board is the opening layout and untouched
//   move_count            completed half-moves, saturating
//   last_captured         most recently captured piece, 0 if none
//   white_lost/black_lost captured-piece counters

module chess_board_store #(
    parameter int MOVE_CNT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [5:0]            wr_addr,
    input  logic [3:0]            wr_piece,
    input  logic                  new_game,
    input  logic [5:0]            rd_addr,
    output logic [3:0]            rd_piece,
    output logic [255:0]          board,
    output logic                  busy,
    output logic                  is_in_initial_state,
    output logic [MOVE_CNT_W-1:0] move_count,
    output logic [3:0]            last_captured,
    output logic [3:0]            white_lost,
    output logic [3:0]            black_lost
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [5:0]            idx_r;
    logic [3:0]            squares_r [64];
    logic                  busy_r;
    logic                  init_flag_r;
    logic [MOVE_CNT_W-1:0] move_count_r;
    logic [3:0]            last_captured_r;
    logic [3:0]            rd_piece_r;

    logic                  start_s;
    logic                  init_last_s;
    logic                  accept_s;
    logic [3:0]            old_s;
    logic                  capture_s;
    logic                  move_done_s;
    logic                  changed_s;

    // Opening-layout value of a square: black on rows 0-1, white on rows 6-7.
    function automatic logic [3:0] opening_piece(input logic [5:0] idx);
        logic [2:0] back_type;
        logic [3:0] piece;
        case (idx[2:0])
            3'd0, 3'd7: back_type = 3'd4;  // rook
            3'd1, 3'd6: back_type = 3'd3;  // knight
            3'd2, 3'd5: back_type = 3'd2;  // bishop
            3'd3:       back_type = 3'd5;  // queen
            3'd4:       back_type = 3'd6;  // king
            default:    back_type = 3'd0;
        endcase
        case (idx[5:3])
            3'd0:    piece = {1'b1, back_type};
            3'd1:    piece = 4'h9;
            3'd6:    piece = 4'h1;
            3'd7:    piece = {1'b0, back_type};
            default: piece = 4'h0;
        endcase
        return piece;
    endfunction

    // Next-state logic and write qualification; new_game beats a same-cycle write.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        init_last_s  = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (new_game) begin
                    next_state_s = INIT;
                    start_s      = 1'b1;
                end else begin
                    accept_s = wr_en;
                end
            end
            INIT: begin
                if (idx_r == 6'd63) begin
                    next_state_s = IDLE;
                    init_last_s  = 1'b1;
                end else begin
                    next_state_s = INIT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Classify the incoming write against the square's current contents.
    always_comb begin
        old_s       = squares_r[wr_addr];
        capture_s   = (old_s[2:0] != 3'd0) && (wr_piece[2:0] != 3'd0) &&
                      (old_s[3] != wr_piece[3]);
        move_done_s = (wr_piece == 4'h0) && (old_s[2:0] != 3'd0);
        changed_s   = (wr_piece != old_s);
    end

    // State register, reload index and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= 6'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == INIT);
            if (start_s) begin
                idx_r <= 6'd0;
            end else if (state_r == INIT) begin
                idx_r <= idx_r + 6'd1;
            end
        end
    end

    // Square storage: parallel opening load on reset, sequenced reload, or a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                squares_r[i] <= opening_piece(6'(i));
            end
        end else if (state_r == INIT) begin
            squares_r[idx_r] <= opening_piece(idx_r);
        end else if (accept_s) begin
            squares_r[wr_addr] <= wr_piece;
        end
    end

    // Renderer read port; samples storage before this cycle's write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_piece_r <= 4'h0;
        end else begin
            rd_piece_r <= squares_r[rd_addr];
        end
    end

    // Game bookkeeping: move count, last capture, initial-position flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_count_r    <= '0;
            last_captured_r <= 4'h0;
            init_flag_r     <= 1'b1;
        end else if (start_s) begin
            move_count_r    <= '0;
            last_captured_r <= 4'h0;
        end else if (init_last_s) begin
            init_flag_r <= 1'b1;
        end else if (accept_s) begin
            if (capture_s) begin
                last_captured_r <= old_s;
            end
            if (move_done_s && (move_count_r != {MOVE_CNT_W{1'b1}})) begin
                move_count_r <= move_count_r + {{(MOVE_CNT_W-1){1'b0}}, 1'b1};
            end
            if (changed_s) begin
                init_flag_r <= 1'b0;
            end
        end
    end

`ifdef BOARD_CAPTURE_LOG_EN
    logic [3:0] white_lost_r;
    logic [3:0] black_lost_r;

    // Per-colour capture counters, saturating at 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            white_lost_r <= 4'h0;
            black_lost_r <= 4'h0;
        end else if (start_s) begin
            white_lost_r <= 4'h0;
            black_lost_r <= 4'h0;
        end else if (accept_s && capture_s) begin
            if (old_s[3] == 1'b0) begin
                if (white_lost_r != 4'hF) white_lost_r <= white_lost_r + 4'h1;
            end else begin
                if (black_lost_r != 4'hF) black_lost_r <= black_lost_r + 4'h1;
            end
        end
    end

    assign white_lost = white_lost_r;
    assign black_lost = black_lost_r;
`else
    assign white_lost = 4'h0;
    assign black_lost = 4'h0;
`endif

    for (genvar g = 0; g < 64; g++) begin : g_board
        assign board[4*g +: 4] = squares_r[g];
    end

    assign rd_piece            = rd_piece_r;
    assign busy                = busy_r;
    assign is_in_initial_state = init_flag_r;
    assign move_count          = move_count_r;
    assign last_captured       = last_captured_r;

endmodule

// File: tb/tb_chess_board_store.sv
module tb_chess_board_store;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [3:0]   wr_piece;
    logic         new_game;
    logic [5:0]   rd_addr;
    logic [3:0]   rd_piece;
    logic [255:0] board;
    logic         busy;
    logic         is_in_initial_state;
    logic [9:0]   move_count;
    logic [3:0]   last_captured;
    logic [3:0]   white_lost;
    logic [3:0]   black_lost;

    int checks_n;
    int errors_n;
    int busy_cycles;
    int guard;
    logic [255:0] opening;
    logic [3:0]   exp_lost_b;
    logic [3:0]   exp_lost_sat;

    chess_board_store #(.MOVE_CNT_W(10)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_piece            (wr_piece),
        .new_game            (new_game),
        .rd_addr             (rd_addr),
        .rd_piece            (rd_piece),
        .board               (board),
        .busy                (busy),
        .is_in_initial_state (is_in_initial_state),
        .move_count          (move_count),
        .last_captured       (last_captured),
        .white_lost          (white_lost),
        .black_lost          (black_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare observed against expected, count, report mismatches.
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] type_of(input byte ch);
        case (ch)
            "P": return 3'd1;
            "B": return 3'd2;
            "N": return 3'd3;
            "R": return 3'd4;
            "Q": return 3'd5;
            "K": return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    // Opening layout built from piece letters, independent of the DUT encoding table.
    function automatic logic [255:0] opening_board();
        logic [255:0] b;
        string back;
        back = "RNBQKBNR";
        b = '0;
        for (int sq = 0; sq < 64; sq++) begin
            int r;
            int c;
            r = sq / 8;
            c = sq % 8;
            if (r == 0)      b[4*sq +: 4] = {1'b1, type_of(back[c])};
            else if (r == 1) b[4*sq +: 4] = {1'b1, type_of("P")};
            else if (r == 6) b[4*sq +: 4] = {1'b0, type_of("P")};
            else if (r == 7) b[4*sq +: 4] = {1'b0, type_of(back[c])};
            else             b[4*sq +: 4] = 4'h0;
        end
        return b;
    endfunction

    task automatic write_sq(input logic [5:0] a, input logic [3:0] p);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_piece = p;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        checks_n = 0; errors_n = 0;
        opening  = opening_board();
`ifdef BOARD_CAPTURE_LOG_EN
        exp_lost_b = 4'd1; exp_lost_sat = 4'd15;
`else
        exp_lost_b = 4'd0; exp_lost_sat = 4'd0;
`endif
        rst = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_piece = 4'h0;
        new_game = 1'b0; rd_addr = 6'd0;
        #2;
        check("rst_board", board, opening);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_init_flag", 256'(is_in_initial_state), 256'd1);
        check("rst_move_count", 256'(move_count), 256'd0);
        check("rst_last_cap", 256'(last_captured), 256'd0);
        check("rst_rd_piece", 256'(rd_piece), 256'd0);
        check("rst_lost", 256'({white_lost, black_lost}), 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Read port
        rd_addr = 6'd0;
        @(negedge clk); check("rd_0", 256'(rd_piece), 256'hC); rd_addr = 6'd4;
        @(negedge clk); check("rd_4", 256'(rd_piece), 256'hE); rd_addr = 6'd60;
        @(negedge clk); check("rd_60", 256'(rd_piece), 256'h6);
        check("sq63", 256'(board[255:252]), 256'h4);
        check("init_flag_idle", 256'(is_in_initial_state), 256'd1);

        // Simple move e2-e4 style
        write_sq(6'd36, 4'h1);
        check("sq36", 256'(board[4*36 +: 4]), 256'h1);
        check("mc_after_place", 256'(move_count), 256'd0);
        write_sq(6'd52, 4'h0);
        check("sq52", 256'(board[4*52 +: 4]), 256'h0);
        check("mc_after_move", 256'(move_count), 256'd1);
        check("init_flag_cleared", 256'(is_in_initial_state), 256'd0);

        // Capture of a black pawn by a white pawn
        write_sq(6'd11, 4'h1);
        check("last_cap", 256'(last_captured), 256'h9);
        check("black_lost", 256'(black_lost), 256'(exp_lost_b));
        check("white_lost", 256'(white_lost), 256'd0);
        // Same-colour overwrite is not a capture
        write_sq(6'd11, 4'h2);
        check("no_cap_same_color", 256'(last_captured), 256'h9);

        // Read during write returns the old value
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'd11; wr_piece = 4'h0; rd_addr = 6'd11;
        @(negedge clk);
        wr_en = 1'b0;
        check("rd_old_value", 256'(rd_piece), 256'h2);
        check("sq11_cleared", 256'(board[4*11 +: 4]), 256'h0);
        check("mc_2", 256'(move_count), 256'd2);

        // Same-value write changes nothing
        write_sq(6'd20, 4'h0);
        check("same_value_mc", 256'(move_count), 256'd2);

        // Reload with a colliding write, and writes attempted while busy
        @(negedge clk);
        new_game = 1'b1; wr_en = 1'b1; wr_addr = 6'd40; wr_piece = 4'h5;
        @(negedge clk);
        new_game = 1'b0; wr_addr = 6'd0; wr_piece = 4'h0;
        busy_cycles = 0; guard = 0;
        while (busy && guard < 200) begin
            busy_cycles++;
            @(negedge clk);
            guard++;
        end
        wr_en = 1'b0;
        check("busy_cycles", 256'(busy_cycles), 256'd64);
        check("busy_fell", 256'(busy), 256'd0);
        check("reload_board", board, opening);
        check("reload_mc", 256'(move_count), 256'd0);
        check("reload_last_cap", 256'(last_captured), 256'd0);
        check("reload_lost", 256'({white_lost, black_lost}), 256'd0);
        check("reload_init_flag", 256'(is_in_initial_state), 256'd1);

        // Reset in the middle of a reload
        write_sq(6'd50, 4'h0);
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_init_busy", 256'(busy), 256'd1);
        check("mid_init_sq50", 256'(board[4*50 +: 4]), 256'h0);
        rst = 1'b1;
        #1;
        check("rst_mid_board", board, opening);
        check("rst_mid_busy", 256'(busy), 256'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_resume_busy", 256'(busy), 256'd0);
        check("no_resume_flag", 256'(is_in_initial_state), 256'd1);

        // Capture counters saturate at 15 (or stay zero without the log)
        write_sq(6'd20, 4'h9);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'd20;
        for (int i = 0; i < 40; i++) begin
            wr_piece = (i % 2 == 0) ? 4'h1 : 4'h9;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("white_lost_sat", 256'(white_lost), 256'(exp_lost_sat));
        check("black_lost_sat", 256'(black_lost), 256'(exp_lost_sat));
        check("last_cap_white", 256'(last_captured), 256'h1);

        // Move counter saturation
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'd21;
        for (int i = 0; i < 2046; i++) begin
            wr_piece = (i % 2 == 0) ? 4'h4 : 4'h0;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("mc_1023", 256'(move_count), 256'd1023);
        write_sq(6'd21, 4'h4);
        write_sq(6'd21, 4'h0);
        check("mc_saturated", 256'(move_count), 256'd1023);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule

// File: doc/chess_board_store.md
# chess_board_store

Authoritative 8x8 chess board register file: holds all 64 squares, initialises them to the standard opening position, applies the single-square writes issued by the game-logic stage, and presents the whole board back as a packed 256-bit vector. It also offers a registered read port for the VGA renderer and a multi-cycle "new game" reload sequencer. Game bookkeeping (move count, initial-position flag, last capture) lives here.

## Interface

Parameters:
- MOVE_CNT_W, 10, width of move counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_en  in  1  write strobe from game logic; one square per cycle.
- wr_addr  in  6  square index; row = addr[5:3] (0 = top), col = addr[2:0].
- wr_piece  in  4  {color, type}; color 0 = WHITE, 1 = BLACK; type 0 = EMPTY, 1 = PAWN, 2 = BISHOP, 3 = KNIGHT, 4 = ROOK, 5 = QUEEN, 6 = KING.
- new_game  in  1  single-cycle pulse requesting a board reload.
- rd_addr  in  6  renderer read address.
- rd_piece  out  4  registered contents of rd_addr.
- board  out  256  packed board; square n at [4n+3:4n].
- busy  out  1  reload sequencer active; writes ignored.
- is_in_initial_state  out  1  board equals the opening layout and no move has been made.
- move_count  out  MOVE_CNT_W  completed half-moves, saturating.
- last_captured  out  4  piece most recently captured; 0 if none.
- white_lost  out  4  white pieces captured (macro-dependent).
- black_lost  out  4  black pieces captured (macro-dependent).

## Operation

- Opening layout:
  - Row 0: black back rank, cols 0–7 = R N B Q K B N R.
  - Row 1: black pawns.
  - Rows 2–5: 4'b0000.
  - Row 6: white pawns.
  - Row 7: white back rank, same column order as row 0.
- States:
  - IDLE: accepts writes and new_game.
  - INIT: reload sequencer.
- IDLE to INIT on new_game. INIT writes one square per cycle, idx 0 to 63, with the opening-layout value. After idx 63 it returns to IDLE.
- In INIT: busy = 1; wr_en is ignored (dropped, not queued); new_game is ignored.
- Entering INIT clears move_count, last_captured, white_lost and black_lost.
- is_in_initial_state is set on the cycle INIT completes.
- Accepted write (IDLE, wr_en = 1): square[wr_addr] <= wr_piece. Let old = square[wr_addr] before the write.
  - If old.type != EMPTY, wr_piece.type != EMPTY and old.color != wr_piece.color: this is a capture; last_captured <= old.
  - If wr_piece == 4'b0000 and old.type != EMPTY: this is a move completion; move_count increments, saturating at all-ones.
  - Any accepted write with wr_piece != old clears is_in_initial_state.
  - A same-value write changes nothing.
- Simultaneous new_game and wr_en in IDLE: new_game wins and the write is dropped.
- rd_piece <= square[rd_addr] every cycle, in both states, using pre-write contents.

## Timing

- Reset (asynchronous): all 64 squares load the opening layout in parallel.
- Reset values of outputs:
  - state = IDLE; busy = 0.
  - is_in_initial_state = 1.
  - move_count = 0; last_captured = 0; white_lost = black_lost = 0.
  - rd_piece = 0.
  - board = opening layout.
- Write latency: the board reflects a write on the cycle after the wr_en edge.
- rd_piece latency is 1 cycle. A read of a square written in the same cycle returns the old value.
- Reload takes 64 cycles. busy rises the cycle after new_game and falls the cycle after idx 63 is written.
- Reset asserted mid-INIT: immediate return to the reset state; the sequence is not resumed.

## Configuration

- BOARD_CAPTURE_LOG_EN defined:
  - On each capture, white_lost increments if old.color = WHITE, otherwise black_lost increments.
  - Each counter saturates at 15.
- BOARD_CAPTURE_LOG_EN undefined:
  - white_lost and black_lost are tied to 0.
  - No counter logic is synthesised.
  - last_captured is still maintained.

## Test plan

- Reset, then read rd_addr = 0, 4 and 60: rd_piece = 4'hC, 4'hE and 4'h6. board[255:252] = 4'h4. is_in_initial_state = 1.
- Write addr 36 := 4'h1, then addr 52 := 4'h0:
  - board square 36 = 4'h1; square 52 = 0.
  - move_count = 1 after the second write.
  - is_in_initial_state = 0.
- Capture: place a white pawn 4'h1 on addr 11 (holds 4'h9). Then:
  - last_captured = 4'h9.
  - black_lost = 1 with the macro, 0 without.
- Pulse new_game with wr_en = 1 on the same cycle:
  - The write is dropped.
  - busy is high for exactly 64 cycles.
  - Writes during busy have no effect.
  - On completion the board equals the opening layout, move_count = 0 and is_in_initial_state = 1.
- Assert rst at INIT idx 30: the board is immediately the full opening layout and busy = 0.
- Preload move_count to all-ones via 1023 moves, then make one more move: move_count stays at 1023.
